iob_native_mem_responder: RTL and testbench
===========================================

Name: iob_native_mem_responder

Overview:
- Subordinate (responder) end of the IOb native bus: accepts avalid/addr/wdata/wstrb requests and returns ready, rvalid and rdata.
- Backed by an internal word-addressed register memory, with a configurable number of read wait states.
- Sits on the SoC side of a CPU data or instruction bus as boot RAM or a simulation memory model.
- Writes produce no response beat; the initiator generates its own write acknowledge from the accepted handshake.

Parameters:
- DATA_W, 32, data width in bits (multiple of 8; wstrb width DATA_W/8)
- ADDR_W, 12, byte-address width; memory depth 2**(ADDR_W-2) words
- WAIT_CYCLES, 0, extra cycles between read acceptance and rvalid (0..255)

Ports:
- clk_i  in  1  clock
- arst_i  in  1  asynchronous active-high reset
- cke_i  in  1  clock enable; when low, all state holds
- iob_avalid_i  in  1  request valid
- iob_addr_i  in  ADDR_W  byte address; bits [1:0] ignored
- iob_wdata_i  in  DATA_W  write data
- iob_wstrb_i  in  DATA_W/8  byte strobes; nonzero = write, zero = read
- iob_ready_o  out  1  responder can accept a request this cycle
- iob_rvalid_o  out  1  read data valid, one-cycle pulse
- iob_rdata_o  out  DATA_W  read data

Behaviour:
- Single clock domain. arst_i is asynchronous and active-high.
- Reset state:
  - FSM = IDLE, wait counter = 0, iob_rdata_o = 0, iob_rvalid_o = 0.
  - iob_ready_o = cke_i, since IDLE is ready.
  - Memory contents are not reset.
- Acceptance: a request is accepted on a rising edge where iob_avalid_i & iob_ready_o & cke_i.
- iob_ready_o = (state == IDLE) & cke_i. This is combinational from the state only; it never depends on iob_avalid_i.
- FSM states: IDLE, WAIT, RESP.
- IDLE, accepted write (wstrb != 0):
  - At that edge, byte lanes with wstrb[i] = 1 are written at mem[addr[ADDR_W-1:2]]; other lanes keep their value.
  - State stays IDLE, so back-to-back writes are accepted every cycle.
  - No rvalid is generated.
- IDLE, accepted read (wstrb == 0):
  - Capture the word index.
  - If WAIT_CYCLES == 0, go to RESP; otherwise load the counter with WAIT_CYCLES-1 and go to WAIT.
- WAIT:
  - ready low; decrement the counter each enabled cycle.
  - When the counter is 0, go to RESP.
- RESP:
  - iob_rvalid_o = 1 for exactly one enabled cycle.
  - iob_rdata_o is registered with mem[captured index] on entry and holds its value until the next read response.
  - Next state is IDLE.
- Read latency: rvalid is asserted WAIT_CYCLES+1 cycles after the acceptance edge. The next request can be accepted the cycle after rvalid, so the minimum read-to-read spacing is WAIT_CYCLES+2 cycles.
- iob_rvalid_o = (state == RESP) & cke_i. When cke_i is low in RESP, the pulse is deferred, never duplicated.
- Read data reflects all writes accepted before the read's acceptance edge. No write can be accepted while a read is in flight.
- iob_avalid_i held high while ready is low is ignored (not queued). The initiator must hold the request until it is accepted.
- A read of a word never written returns X in simulation. The bench must pre-write before reading.
- Reset asserted mid-read (WAIT or RESP): the transaction is discarded with no rvalid, and the FSM returns to IDLE immediately.
- Address wrap: bits above ADDR_W are not present, so indexing wraps modulo the depth.

Test Plan:
- Write 0xDEADBEEF to 0x010 with wstrb=0xF, then read 0x010 (WAIT_CYCLES=0):
  - ready is high on both acceptances.
  - rvalid pulses 1 cycle after read acceptance with rdata=0xDEADBEEF.
  - ready is low during RESP.
- Partial strobes: write 0x11223344 to 0x020 (0xF), then 0xAABBCCDD with wstrb=0x5, then read -> rdata=0x11BB33DD.
- WAIT_CYCLES=3, read of pre-written 0x00000055 at 0x004:
  - ready is low for 4 cycles after acceptance.
  - rvalid occurs exactly 4 cycles after acceptance with rdata=0x55.
  - Only one rvalid pulse.
- Back-to-back: 8 writes on 8 consecutive cycles with avalid held high -> all accepted, ready never drops. Readback of each returns the written values.
- cke_i low for 2 cycles while in RESP:
  - rvalid stays 0 during those cycles.
  - It pulses once when cke_i returns high; data is unchanged.
- arst_i pulsed while in WAIT (WAIT_CYCLES=5):
  - No rvalid ever appears for that read; rdata_o=0 and ready is high after release.
  - A subsequent read returns correct data.

Source files
------------

// File: rtl/iob_native_mem_responder.sv
// IOb native bus responder backed by a word-addressed register memory.
// Writes complete in the acceptance cycle; reads return one rvalid pulse after WAIT_CYCLES extra cycles.
module iob_native_mem_responder #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 12,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                clk_i,
    input  logic                arst_i,
    input  logic                cke_i,
    input  logic                iob_avalid_i,
    input  logic [ADDR_W-1:0]   iob_addr_i,
    input  logic [DATA_W-1:0]   iob_wdata_i,
    input  logic [DATA_W/8-1:0] iob_wstrb_i,
    output logic                iob_ready_o,
    output logic                iob_rvalid_o,
    output logic [DATA_W-1:0]   iob_rdata_o
);

    localparam int STRB_W = DATA_W / 8;
    localparam int DEPTH  = 2 ** (ADDR_W - 2);
    localparam logic [7:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 8'd0 : 8'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state;
    logic [7:0]        wait_cnt;
    logic [ADDR_W-3:0] rd_idx;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-3:0] addr_idx;
    logic              accept;
    logic              is_write;
    logic              unused_addr;

    assign addr_idx    = iob_addr_i[ADDR_W-1:2];
    assign unused_addr = ^iob_addr_i[1:0];
    assign is_write    = (iob_wstrb_i != '0);

    assign iob_ready_o  = (state == S_IDLE) & cke_i;
    assign iob_rvalid_o = (state == S_RESP) & cke_i;
    assign accept       = iob_avalid_i & iob_ready_o;

    // Memory array carries no reset so it maps onto plain storage.
    always_ff @(posedge clk_i) begin
        if (accept && is_write) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (iob_wstrb_i[i]) begin
                    mem[addr_idx][8*i +: 8] <= iob_wdata_i[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            rd_idx      <= '0;
            iob_rdata_o <= '0;
        end else if (cke_i) begin
            case (state)
                S_IDLE: begin
                    if (accept && !is_write) begin
                        rd_idx <= addr_idx;
                        if (WAIT_CYCLES == 0) begin
                            iob_rdata_o <= mem[addr_idx];
                            state       <= S_RESP;
                        end else begin
                            wait_cnt <= WAIT_LOAD;
                            state    <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // rdata is loaded on the edge that enters RESP so it is valid with rvalid.
                    if (wait_cnt == 8'd0) begin
                        iob_rdata_o <= mem[rd_idx];
                        state       <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iob_native_mem_responder.sv
// Directed bench for iob_native_mem_responder: three instances with WAIT_CYCLES of 0, 3 and 5
// share clock, reset, clock enable and request buses; each has its own avalid.
module tb_iob_native_mem_responder;

    logic        clk;
    logic        arst;
    logic        cke;
    logic        avalid [3];
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready  [3];
    logic        rvalid [3];
    logic [31:0] rdata  [3];

    int n_tests;
    int n_fail;

    iob_native_mem_responder #(.DATA_W(32), .ADDR_W(12), .WAIT_CYCLES(0)) u_dut0 (
        .clk_i(clk), .arst_i(arst), .cke_i(cke), .iob_avalid_i(avalid[0]),
        .iob_addr_i(addr), .iob_wdata_i(wdata), .iob_wstrb_i(wstrb),
        .iob_ready_o(ready[0]), .iob_rvalid_o(rvalid[0]), .iob_rdata_o(rdata[0])
    );

    iob_native_mem_responder #(.DATA_W(32), .ADDR_W(12), .WAIT_CYCLES(3)) u_dut1 (
        .clk_i(clk), .arst_i(arst), .cke_i(cke), .iob_avalid_i(avalid[1]),
        .iob_addr_i(addr), .iob_wdata_i(wdata), .iob_wstrb_i(wstrb),
        .iob_ready_o(ready[1]), .iob_rvalid_o(rvalid[1]), .iob_rdata_o(rdata[1])
    );

    iob_native_mem_responder #(.DATA_W(32), .ADDR_W(12), .WAIT_CYCLES(5)) u_dut2 (
        .clk_i(clk), .arst_i(arst), .cke_i(cke), .iob_avalid_i(avalid[2]),
        .iob_addr_i(addr), .iob_wdata_i(wdata), .iob_wstrb_i(wstrb),
        .iob_ready_o(ready[2]), .iob_rvalid_o(rvalid[2]), .iob_rdata_o(rdata[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_write(input int d, input logic [11:0] a, input logic [31:0] dat,
                            input logic [3:0] s);
        @(negedge clk);
        avalid[d] = 1'b1;
        addr      = a;
        wdata     = dat;
        wstrb     = s;
        chk("write_ready", 32'(ready[d]), 32'd1);
        @(negedge clk);
        avalid[d] = 1'b0;
        wstrb     = 4'h0;
    endtask

    // Issues a read, then walks the exact cycle-by-cycle response window.
    task automatic do_read(input int d, input logic [11:0] a, input logic [31:0] exp,
                           input int waitc);
        @(negedge clk);
        avalid[d] = 1'b1;
        addr      = a;
        wstrb     = 4'h0;
        chk("read_ready", 32'(ready[d]), 32'd1);
        @(negedge clk);
        avalid[d] = 1'b0;
        for (int n = 1; n <= waitc + 1; n++) begin
            chk("busy_ready", 32'(ready[d]), 32'd0);
            if (n <= waitc) begin
                chk("early_rvalid", 32'(rvalid[d]), 32'd0);
            end else begin
                chk("rvalid", 32'(rvalid[d]), 32'd1);
                chk("rdata", rdata[d], exp);
            end
            @(negedge clk);
        end
        chk("post_rvalid", 32'(rvalid[d]), 32'd0);
        chk("post_ready", 32'(ready[d]), 32'd1);
        chk("rdata_hold", rdata[d], exp);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        arst    = 1'b1;
        cke     = 1'b1;
        addr    = '0;
        wdata   = '0;
        wstrb   = '0;
        for (int i = 0; i < 3; i++) avalid[i] = 1'b0;

        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_ready", 32'(ready[i]), 32'd1);
            chk("rst_rvalid", 32'(rvalid[i]), 32'd0);
            chk("rst_rdata", rdata[i], 32'd0);
        end
        cke = 1'b0;
        #1;
        chk("rst_ready_cke0", 32'(ready[0]), 32'd0);
        cke  = 1'b1;
        arst = 1'b0;

        // Basic write/read, zero wait states.
        do_write(0, 12'h010, 32'hDEADBEEF, 4'hF);
        do_read(0, 12'h010, 32'hDEADBEEF, 0);
        do_read(0, 12'h013, 32'hDEADBEEF, 0);

        // Partial byte strobes.
        do_write(0, 12'h020, 32'h11223344, 4'hF);
        do_write(0, 12'h020, 32'hAABBCCDD, 4'h5);
        do_read(0, 12'h020, 32'h11BB33DD, 0);

        // Three wait states.
        do_write(1, 12'h004, 32'h00000055, 4'hF);
        do_read(1, 12'h004, 32'h00000055, 3);

        // Back-to-back writes with avalid held high.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            avalid[0] = 1'b1;
            addr      = 12'(12'h100 + 4 * i);
            wdata     = 32'hC0DE0000 + 32'(i * 32'h00010101);
            wstrb     = 4'hF;
            chk("b2b_ready", 32'(ready[0]), 32'd1);
        end
        @(negedge clk);
        avalid[0] = 1'b0;
        wstrb     = 4'h0;
        for (int i = 0; i < 8; i++) begin
            do_read(0, 12'(12'h100 + 4 * i), 32'hC0DE0000 + 32'(i * 32'h00010101), 0);
        end

        // Clock enable dropped for two cycles while in RESP.
        do_write(0, 12'h040, 32'h0BADF00D, 4'hF);
        @(negedge clk);
        avalid[0] = 1'b1;
        addr      = 12'h040;
        wstrb     = 4'h0;
        @(negedge clk);
        avalid[0] = 1'b0;
        cke       = 1'b0;
        #1;
        chk("cke0_rvalid_a", 32'(rvalid[0]), 32'd0);
        @(negedge clk);
        chk("cke0_rvalid_b", 32'(rvalid[0]), 32'd0);
        chk("cke0_ready", 32'(ready[0]), 32'd0);
        @(negedge clk);
        chk("cke0_rvalid_c", 32'(rvalid[0]), 32'd0);
        cke = 1'b1;
        #1;
        chk("cke1_rvalid", 32'(rvalid[0]), 32'd1);
        chk("cke1_rdata", rdata[0], 32'h0BADF00D);
        @(negedge clk);
        chk("cke1_single_pulse", 32'(rvalid[0]), 32'd0);
        chk("cke1_ready", 32'(ready[0]), 32'd1);
        chk("cke1_rdata_hold", rdata[0], 32'h0BADF00D);

        // Reset pulsed while a read waits.
        do_write(2, 12'h008, 32'h12345678, 4'hF);
        @(negedge clk);
        avalid[2] = 1'b1;
        addr      = 12'h008;
        wstrb     = 4'h0;
        @(negedge clk);
        avalid[2] = 1'b0;
        @(negedge clk);
        chk("wait_ready", 32'(ready[2]), 32'd0);
        arst = 1'b1;
        #2;
        arst = 1'b0;
        #1;
        chk("arst_ready", 32'(ready[2]), 32'd1);
        chk("arst_rdata", rdata[2], 32'd0);
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            chk("arst_no_rvalid", 32'(rvalid[2]), 32'd0);
        end
        do_read(2, 12'h008, 32'h12345678, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
